// File: rtl/game_controller.sv
// ============================================================================
// Module      : game_controller
// Description : Reaction-game sequencer: flash, count down, judge the player's
//               stop against a latched target and track a win streak.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_controller #(
    parameter int FLASH_TICKS  = 8,
    parameter int RESULT_TICKS = 16
) (
    input  logic       clk_4_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [4:0] random_i,
    input  logic [4:0] count_i,
    output logic       counter_en_o,
    output logic       counter_rst_no,
    output logic [4:0] target_o,
    output logic       blank_o,
    output logic       win_o,
    output logic       lose_o,
    output logic [3:0] score_o
);

    localparam int MAX_TICKS = (FLASH_TICKS > RESULT_TICKS) ? FLASH_TICKS : RESULT_TICKS;
    localparam int TW        = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TW-1:0] FLASH_LAST  = TW'(FLASH_TICKS - 1);
    localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        STARTING     = 3'd1,
        DECREMENTING = 3'd2,
        CORRECT      = 3'd3,
        WRONG        = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [4:0]      target;
    logic [3:0]      score;

    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            state  <= IDLE;
            timer  <= '0;
            target <= '0;
            score  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (state == STARTING || state == CORRECT || state == WRONG)
                timer <= timer + 1'b1;

            if (state == IDLE && start_i)
                target <= random_i;

            // Streak updates only on entry to a result state.
            if (state == DECREMENTING && state_next == CORRECT && score != 4'hF)
                score <= score + 1'b1;
            else if (state == DECREMENTING && state_next == WRONG)
                score <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (start_i) state_next = STARTING;
            STARTING:     if (timer == FLASH_LAST) state_next = DECREMENTING;
            DECREMENTING: begin
                // A stop outranks the timeout so a zero target can still win.
                if (stop_i)
                    state_next = (count_i == target) ? CORRECT : WRONG;
                else if (count_i == 5'd0)
                    state_next = WRONG;
            end
            CORRECT, WRONG: if (timer == RESULT_LAST) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_comb begin
        counter_en_o   = 1'b0;
        counter_rst_no = 1'b0;
        blank_o        = 1'b0;
        win_o          = 1'b0;
        lose_o         = 1'b0;
        if (!rst_i) begin
            case (state)
                STARTING:     blank_o = timer[0];
                DECREMENTING: begin
                    counter_rst_no = 1'b1;
                    counter_en_o   = !stop_i && (count_i != 5'd0);
                end
                CORRECT: begin
                    counter_rst_no = 1'b1;
                    win_o          = 1'b1;
                end
                WRONG: begin
                    counter_rst_no = 1'b1;
                    lose_o         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign target_o = target;
    assign score_o  = score;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ============================================================================
// Module      : tb_game_controller
// Description : Randomized self-checking bench with a phase/duration model of
//               the game and a behavioural down-counter as the environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_controller;

    localparam int FLASH_TICKS  = 8;
    localparam int RESULT_TICKS = 16;

    logic       clk_4_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       stop_i;
    logic [4:0] random_i;
    logic [4:0] count_i;
    logic       counter_en_o;
    logic       counter_rst_no;
    logic [4:0] target_o;
    logic       blank_o;
    logic       win_o;
    logic       lose_o;
    logic [3:0] score_o;

    int checks = 0;
    int errors = 0;

    game_controller #(
        .FLASH_TICKS  (FLASH_TICKS),
        .RESULT_TICKS (RESULT_TICKS)
    ) dut (
        .clk_4_i        (clk_4_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .random_i       (random_i),
        .count_i        (count_i),
        .counter_en_o   (counter_en_o),
        .counter_rst_no (counter_rst_no),
        .target_o       (target_o),
        .blank_o        (blank_o),
        .win_o          (win_o),
        .lose_o         (lose_o),
        .score_o        (score_o)
    );

    always #5 clk_4_i = ~clk_4_i;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model phases: the game is described as how long it has been in which phase.
    localparam int PH_IDLE = 0, PH_FLASH = 1, PH_RUN = 2, PH_WIN = 3, PH_LOSE = 4;

    int phase = PH_IDLE, elapsed = 0, m_target = 0, m_score = 0;
    int n_phase, n_elapsed, n_target, n_score, n_count;
    int wins_seen = 0, losses_seen = 0;
    bit primed = 0;

    initial begin
        int e_en, e_rstn, e_blank, e_win, e_lose;
        count_i  = 5'h1F;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        random_i = 5'd0;
        n_phase = PH_IDLE; n_elapsed = 0; n_target = 0; n_score = 0; n_count = 31;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk_4_i);
            phase = n_phase; elapsed = n_elapsed; m_target = n_target;
            m_score = n_score; count_i = 5'(n_count);

            // First 3 cycles: reset. Then random play, then a streak-building stretch.
            if (cyc < 3) begin
                rst_i = 1'b1; start_i = $urandom_range(0, 1); stop_i = $urandom_range(0, 1);
            end else if (cyc < 3000) begin
                rst_i   = ($urandom_range(0, 249) == 0);
                start_i = ($urandom_range(0, 3) == 0);
                stop_i  = (int'(count_i) == m_target && $urandom_range(0, 1) == 1)
                          || ($urandom_range(0, 24) == 0);
            end else begin
                rst_i   = 1'b0;
                start_i = 1'b1;
                stop_i  = (int'(count_i) == m_target) || ($urandom_range(0, 1) == 1 && phase != PH_RUN);
            end
            random_i = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            #1;

            e_en = 0; e_rstn = 0; e_blank = 0; e_win = 0; e_lose = 0;
            if (!rst_i) begin
                case (phase)
                    PH_FLASH: e_blank = elapsed % 2;
                    PH_RUN:   begin e_rstn = 1; e_en = (!stop_i && count_i != 0) ? 1 : 0; end
                    PH_WIN:   begin e_rstn = 1; e_win = 1; end
                    PH_LOSE:  begin e_rstn = 1; e_lose = 1; end
                    default:  ;
                endcase
            end
            check("counter_en",  int'(counter_en_o),   e_en);
            check("counter_rst", int'(counter_rst_no), e_rstn);
            check("blank",       int'(blank_o),        e_blank);
            check("win",         int'(win_o),          e_win);
            check("lose",        int'(lose_o),         e_lose);
            if (primed) begin
                check("target", int'(target_o), m_target);
                check("score",  int'(score_o),  m_score);
            end

            n_phase = phase; n_elapsed = elapsed; n_target = m_target; n_score = m_score;
            if (rst_i) begin
                n_phase = PH_IDLE; n_elapsed = 0; n_target = 0; n_score = 0;
            end else begin
                case (phase)
                    PH_IDLE: if (start_i) begin
                        n_target = int'(random_i); n_phase = PH_FLASH; n_elapsed = 0;
                    end
                    PH_FLASH: begin
                        n_elapsed = elapsed + 1;
                        if (n_elapsed == FLASH_TICKS) begin n_phase = PH_RUN; n_elapsed = 0; end
                    end
                    PH_RUN: begin
                        if (stop_i && int'(count_i) == m_target) begin
                            n_phase = PH_WIN; n_score = (m_score < 15) ? m_score + 1 : 15;
                            wins_seen++;
                        end else if (stop_i || count_i == 0) begin
                            n_phase = PH_LOSE; n_score = 0; losses_seen++;
                        end
                        n_elapsed = 0;
                    end
                    default: begin
                        n_elapsed = elapsed + 1;
                        if (n_elapsed == RESULT_TICKS) begin n_phase = PH_IDLE; n_elapsed = 0; end
                    end
                endcase
            end
            // Environment: the down-counter the controller drives.
            if (e_rstn == 0)   n_count = 31;
            else if (e_en == 1) n_count = int'(count_i) - 1;
            else               n_count = int'(count_i);
            primed = 1;
        end

        check("streak_saturated", int'(score_o), 15);
        check("some_wins",   (wins_seen > 16) ? 1 : 0, 1);
        check("some_losses", (losses_seen > 0) ? 1 : 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter FLASH_TICKS, default 8, giving the STARTING duration in clk_4_i cycles (>=2).
REQ-002 SHALL have parameter RESULT_TICKS, default 16, giving the CORRECT/WRONG hold duration in clk_4_i cycles (>=2).
REQ-003 SHALL have port clk_4_i, input, 1 bit: 4 Hz game clock, the only clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start_i, input, 1 bit: debounced start request, sampled each cycle.
REQ-006 SHALL have port stop_i, input, 1 bit: debounced player stop request, sampled each cycle.
REQ-007 SHALL have port random_i, input, 5 bits: pseudo-random target source.
REQ-008 SHALL have port count_i, input, 5 bits: current value from the game down-counter.
REQ-009 SHALL have port counter_en_o, output, 1 bit: enables the down-counter decrement.
REQ-010 SHALL have port counter_rst_no, output, 1 bit: active-low counter reset; 0 holds the counter at 5'h1F.
REQ-011 SHALL have port target_o, output, 5 bits: the latched target value.
REQ-012 SHALL have port blank_o, output, 1 bit: display blank used for the flashing effect.
REQ-013 SHALL have port win_o, output, 1 bit: correct-stop indicator.
REQ-014 SHALL have port lose_o, output, 1 bit: wrong-stop or timeout indicator.
REQ-015 SHALL have port score_o, output, 4 bits: consecutive-win streak.

Function
REQ-016 SHALL implement five states: IDLE, STARTING, DECREMENTING, CORRECT, WRONG; all transitions take effect on the next clk_4_i edge.
REQ-017 SHALL use an internal tick timer wide enough to hold max(FLASH_TICKS, RESULT_TICKS)-1, and SHALL clear it on every state transition.
REQ-018 In IDLE, SHALL drive counter_rst_no=0, counter_en_o=0, win_o=0, lose_o=0, blank_o=0.
REQ-019 On start_i=1 in IDLE, SHALL latch target_o<=random_i and SHALL enter STARTING.
REQ-020 In STARTING, SHALL drive counter_rst_no=0 and counter_en_o=0, and SHALL drive blank_o equal to timer bit 0 (toggling each cycle, starting at 0).
REQ-021 In STARTING, SHALL increment the timer, and when timer==FLASH_TICKS-1 SHALL enter DECREMENTING.
REQ-022 In DECREMENTING, SHALL drive counter_rst_no=1 and blank_o=0, and SHALL drive counter_en_o=1 combinationally unless stop_i=1 in the same cycle, so the counter freezes on the compared value.
REQ-023 In DECREMENTING with stop_i=1, SHALL enter CORRECT if count_i==target_o and SHALL enter WRONG otherwise.
REQ-024 In DECREMENTING with stop_i=0 and count_i==0, SHALL enter WRONG (timeout), with counter_en_o=0 in that cycle so the counter never wraps.
REQ-025 When stop_i=1 and count_i==0 occur together, SHALL give the stop comparison priority (target 0 wins).
REQ-026 In CORRECT, SHALL drive win_o=1, lose_o=0, counter_rst_no=1, counter_en_o=0, holding the frozen count on display.
REQ-027 In WRONG, SHALL drive lose_o=1, win_o=0, counter_rst_no=1, counter_en_o=0.
REQ-028 On entry to CORRECT, SHALL increment score_o, saturating at 15.
REQ-029 On entry to WRONG, SHALL clear score_o to 0.
REQ-030 In CORRECT and WRONG, SHALL count the timer and return to IDLE when timer==RESULT_TICKS-1.
REQ-031 SHALL ignore start_i outside IDLE and stop_i outside DECREMENTING.
REQ-032 SHALL hold target_o stable from latch until the next IDLE start.

Reset
REQ-033 When rst_i=1 at a clk_4_i edge in any state, SHALL force IDLE, timer=0, target_o=0, score_o=0.
REQ-034 During reset, outputs SHALL follow the IDLE rules (counter_rst_no=0, counter_en_o=0, win_o=0, lose_o=0, blank_o=0).

Verification
REQ-035 Scenario: reset, random_i=5'd20, start_i pulse -> target_o=20, blank_o toggles 0,1 for 8 cycles, then counter_en_o=1.
REQ-036 Scenario: stop_i with count_i=20 and target 20 -> counter_en_o=0 in that cycle, win_o=1 for 16 cycles, score_o=1, then IDLE.
REQ-037 Scenario: stop_i with count_i=19 and target 20 -> lose_o=1, score_o=0.
REQ-038 Scenario: no stop, count_i reaches 0 with target 7 -> WRONG; counter_en_o=0 at count 0.
REQ-039 Scenario: target 0, stop_i while count_i=0 -> CORRECT; 16 straight wins -> score_o stays 15.
REQ-040 Scenario: rst_i asserted mid-DECREMENTING, with start_i and stop_i pulsed during CORRECT -> IDLE with all outputs reset next cycle; the pulses have no effect.
